// File: rtl/img_mem_pkg.sv
// Shared constants, owner encoding and pipeline tag for the image memory arbiter.
package img_mem_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 32761;   // 181 * 181 RGB332 pixels
    localparam logic [3:0] STARVE_LIM = 4'd8;

    // Who owns a memory slot; OWN_CLI marks client reads that return data.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CLI  = 2'd2
    } owner_e;

    // Travels alongside an access so the returning mem_rdata reaches the right requester.
    typedef struct packed {
        owner_e owner;
        logic   err;     // out-of-range client access
        logic   steal;   // client took a slot the VGA path wanted
    } tag_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < MEM_DEPTH;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles a client request has waited; flags when the limit is reached.
import img_mem_pkg::*;

module arb_starve_cnt #(
    parameter logic [3:0] LIMIT = STARVE_LIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    logic [3:0] wait_cnt;

    // Count waiting cycles; any grant or a dropped request restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!req || gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign starved = (wait_cnt == LIMIT);

endmodule

// File: rtl/img_mem_arbiter.sv
// Arbitrates the single-port image RAM between the VGA sprite path and a client port.
// Slot decision -> registered mem_* -> registered results: two-cycle read latency.
import img_mem_pkg::*;

module img_mem_arbiter #(
    parameter logic [3:0] STARVE = STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              vga_blank,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_underrun,
    input  logic              cli_req,
    input  logic              cli_we,
    input  logic [ADDR_W-1:0] cli_addr,
    input  logic [DATA_W-1:0] cli_wdata,
    output logic              cli_gnt,
    output logic [DATA_W-1:0] cli_rdata,
    output logic              cli_rvalid,
    output logic              cli_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic vga_req;
    logic cli_oob;
    logic starved;
    tag_t tag_nxt;
    tag_t tag_q;

    arb_starve_cnt #(
        .LIMIT (STARVE)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (cli_req),
        .gnt     (cli_gnt),
        .starved (starved)
    );

    // Slot decision: a starved client steals, otherwise active-video VGA wins, else the client.
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        vga_req = pix_en & ~vga_blank;
        cli_oob = ~addr_in_range(cli_addr);
        cli_gnt = cli_req & (starved | ~vga_req);
        tag_nxt = '0;
        if (cli_gnt) begin
            tag_nxt.owner = cli_we ? OWN_NONE : OWN_CLI;
            tag_nxt.err   = cli_oob;
            tag_nxt.steal = vga_req;
        end else if (vga_req) begin
            tag_nxt.owner = OWN_VGA;
        end
    end

    // Issue stage: register the winning access onto the memory port and launch its tag.
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            tag_q     <= '0;
        end else begin
            tag_q  <= tag_nxt;
            mem_we <= 1'b0;
            if (cli_gnt) begin
                mem_addr <= cli_oob ? '0 : cli_addr;
                mem_we   <= cli_we & ~cli_oob;
                if (cli_we && !cli_oob) begin
                    mem_wdata <= cli_wdata;
                end
            end else if (vga_req) begin
                mem_addr <= vga_addr;
            end
        end
    end

    // Return stage: steer mem_rdata to its owner using the tag issued one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_data     <= '0;
            vga_valid    <= 1'b0;
            vga_underrun <= 1'b0;
            cli_rdata    <= '0;
            cli_rvalid   <= 1'b0;
            cli_err      <= 1'b0;
        end else begin
            vga_valid    <= (tag_q.owner == OWN_VGA);
            cli_rvalid   <= (tag_q.owner == OWN_CLI);
            cli_err      <= tag_q.err;
            vga_underrun <= tag_q.steal;
            if (tag_q.owner == OWN_VGA) begin
                vga_data <= mem_rdata;
            end
            if (tag_q.owner == OWN_CLI) begin
                cli_rdata <= tag_q.err ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Randomized self-checking bench for img_mem_arbiter against a transaction-level model.
module tb_img_mem_arbiter;
    import img_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_en, vga_blank;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid, vga_underrun;
    logic              cli_req, cli_we;
    logic [ADDR_W-1:0] cli_addr;
    logic [DATA_W-1:0] cli_wdata;
    logic              cli_gnt;
    logic [DATA_W-1:0] cli_rdata;
    logic              cli_rvalid, cli_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    img_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .vga_blank    (vga_blank),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .vga_valid    (vga_valid),
        .vga_underrun (vga_underrun),
        .cli_req      (cli_req),
        .cli_we       (cli_we),
        .cli_addr     (cli_addr),
        .cli_wdata    (cli_wdata),
        .cli_gnt      (cli_gnt),
        .cli_rdata    (cli_rdata),
        .cli_rvalid   (cli_rvalid),
        .cli_err      (cli_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Image RAM: write lands mid-cycle, read is combinational from the registered address.
    logic [7:0] tb_mem  [32768];
    logic [7:0] ref_mem [32768];
    assign mem_rdata = tb_mem[mem_addr];
    always @(negedge clk) begin
        if (mem_we) tb_mem[mem_addr] = mem_wdata;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Expected events per cycle, ring-indexed by cycle number.
    bit         e_we [4], e_addr0 [4], e_vv [4], e_ur [4], e_rv [4], e_err [4];
    logic [7:0] e_vd [4], e_rd [4], e_wd [4];
    logic [14:0] e_wa [4];
    logic [7:0] last_vd;
    int         wait_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_slot(input int s);
        e_we[s] = 0; e_addr0[s] = 0; e_vv[s] = 0; e_ur[s] = 0; e_rv[s] = 0; e_err[s] = 0;
        e_vd[s] = '0; e_rd[s] = '0; e_wd[s] = '0; e_wa[s] = '0;
    endtask

    task automatic drive_idle();
        pix_en = 0; vga_blank = 0; vga_addr = '0;
        cli_req = 0; cli_we = 0; cli_addr = '0; cli_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vga_data"}, vga_data, 0);
        check({tag, "_vga_valid"}, vga_valid, 0);
        check({tag, "_underrun"}, vga_underrun, 0);
        check({tag, "_cli_rdata"}, cli_rdata, 0);
        check({tag, "_cli_rvalid"}, cli_rvalid, 0);
        check({tag, "_cli_err"}, cli_err, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cli_gnt"}, cli_gnt, 0);
    endtask

    // Asynchronous reset mid-cycle; everything in flight is forgotten by the model too.
    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        #1;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1;
        for (int i = 0; i < 4; i++) clear_slot(i);
        wait_m  = 0;
        last_vd = '0;
        cyc     = 0;
    endtask

    // One cycle: apply inputs, predict the grant and the results two cycles out, then check.
    task automatic step(input bit pe, input bit bl, input bit rq, input bit we,
                        input logic [14:0] ca, input logic [7:0] wd, input logic [14:0] va,
                        output bit granted, output bit dut_g);
        bit vreq, g, oob;
        int s1, s2, s;
        pix_en = pe; vga_blank = bl; vga_addr = va;
        cli_req = rq; cli_we = we; cli_addr = ca; cli_wdata = wd;
        #1;
        vreq = pe && !bl;
        g    = rq && (wait_m >= int'(STARVE_LIM) || !vreq);
        dut_g = cli_gnt;
        check("cli_gnt", cli_gnt, g);
        s1 = (cyc + 1) & 3;
        s2 = (cyc + 2) & 3;
        if (g) begin
            oob = int'(ca) >= MEM_DEPTH;
            e_ur[s2] = vreq;
            if (oob) begin
                e_err[s2]   = 1;
                e_addr0[s1] = 1;
                if (!we) begin e_rv[s2] = 1; e_rd[s2] = 8'h00; end
            end else if (we) begin
                e_we[s1] = 1; e_wa[s1] = ca; e_wd[s1] = wd;
                ref_mem[ca] = wd;
            end else begin
                e_rv[s2] = 1; e_rd[s2] = ref_mem[ca];
            end
        end else if (vreq) begin
            e_vv[s2] = 1; e_vd[s2] = ref_mem[va];
        end
        wait_m  = (!rq || g) ? 0 : ((wait_m < 15) ? wait_m + 1 : 15);
        granted = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        s = cyc & 3;
        check("mem_we", mem_we, e_we[s]);
        if (e_we[s]) begin
            check("mem_waddr", mem_addr, e_wa[s]);
            check("mem_wdata", mem_wdata, e_wd[s]);
        end
        if (e_addr0[s]) check("mem_addr_oob", mem_addr, 0);
        if (e_vv[s]) last_vd = e_vd[s];
        check("vga_valid", vga_valid, e_vv[s]);
        check("vga_data", vga_data, last_vd);
        check("vga_underrun", vga_underrun, e_ur[s]);
        check("cli_rvalid", cli_rvalid, e_rv[s]);
        check("cli_err", cli_err, e_err[s]);
        if (e_rv[s]) check("cli_rdata", cli_rdata, e_rd[s]);
        clear_slot(s);
    endtask

    function automatic logic [14:0] rand_cli_addr();
        int r = int'($urandom_range(0, 7));
        if (r == 0) return 15'(MEM_DEPTH + int'($urandom_range(0, 6)));
        if (r < 5)  return 15'($urandom_range(0, 15));
        return 15'($urandom_range(0, MEM_DEPTH - 1));
    endfunction

    bit g, dg;
    int n;
    bit         p_act, p_we;
    logic [14:0] p_addr;
    logic [7:0]  p_wd;

    // Client transaction held stable until granted, under a given VGA pattern mode.
    task automatic run_random(input int cycles, input int mode);
        bit pe, bl;
        for (int k = 0; k < cycles; k++) begin
            if (!p_act && $urandom_range(0, 99) < 60) begin
                p_act  = 1;
                p_we   = $urandom_range(0, 1) == 1;
                p_addr = rand_cli_addr();
                p_wd   = 8'($urandom);
            end else if (p_act && $urandom_range(0, 99) < 3) begin
                p_act = 0;
            end
            case (mode)
                0: begin pe = k[0]; bl = 0; end
                1: begin pe = 1; bl = 0; end
                default: begin pe = $urandom_range(0, 1) == 1; bl = $urandom_range(0, 3) == 0; end
            endcase
            step(pe, bl, p_act, p_we, p_addr, p_wd, 15'($urandom_range(0, MEM_DEPTH - 1)), g, dg);
            if (g) p_act = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            tb_mem[i]  = 8'((i * 37) ^ (i >> 7));
            ref_mem[i] = tb_mem[i];
        end
        rst_n = 1;
        drive_idle();
        #2;
        do_reset();

        // Reset with a client read in flight: its rvalid must never appear.
        step(0, 0, 1, 0, 15'h0010, 8'h00, 15'h0, g, dg);
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 15'h0, 8'h0, 15'h0, g, dg);

        // Alternate pixel strobes in active video, client reads 5..8.
        n = 0;
        for (int a = 5; a <= 8; a++) begin
            for (int t = 0; t < 20; t++) begin
                step(n[0], 0, 1, 0, 15'(a), 8'h00, 15'(100 + n), g, dg);
                n++;
                if (g) break;
            end
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 15'h0, 8'h0, 15'h0, g, dg);

        // Blanking: client write then read-back of 0x0100, VGA ignored.
        step(1, 1, 1, 1, 15'h0100, 8'hA5, 15'h0200, g, dg);
        step(1, 1, 1, 0, 15'h0100, 8'h00, 15'h0200, g, dg);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 15'h0, 8'h0, 15'h0200, g, dg);
        check("raw_a5_written", tb_mem[15'h0100], 8'hA5);

        // Back-to-back pixel strobes: client must steal after exactly 8 waits.
        n = 0;
        for (int t = 0; t < 20; t++) begin
            step(1, 0, 1, 0, 15'h0033, 8'h00, 15'(300 + t), g, dg);
            if (dg) break;
            n++;
        end
        check("starve_waits", n, 8);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 15'h0, 8'h0, 15'h0040, g, dg);

        // Out-of-range read and write.
        step(0, 0, 1, 0, 15'd32761, 8'h00, 15'h0, g, dg);
        step(0, 0, 1, 1, 15'h7FFF, 8'h5A, 15'h0, g, dg);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 15'h0, 8'h0, 15'h0, g, dg);

        // Randomized phases.
        p_act = 0;
        run_random(200, 0);
        run_random(200, 1);
        run_random(600, 2);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 15'h0, 8'h0, 15'h0, g, dg);

        n = 0;
        for (int i = 0; i < 32768; i++) if (tb_mem[i] !== ref_mem[i]) n++;
        check("mem_contents", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
